paddles: RTL and testbench

Paddle position generator for the pong datapath. It samples the four raw player push-buttons (left and right player, up and down each), synchronises and debounces them, and moves two paddle top-edge coordinates at a fixed frame-tick rate, clamped to the playfield. Its outputs `posbarraiy`/`posbarrady` feed the ball-motion block's paddle inputs and the VGA renderer directly.

---
 rtl/paddles_pkg.sv | 30 +++
 rtl/paddles_debounce.sv | 39 +++
 rtl/paddles.sv | 72 +++++++
 tb/tb_paddles.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/paddles_pkg.sv
// Playfield constants and move decoding shared by the paddle generator,
// ball motion and the renderer.
package paddles_pkg;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned CALC_W  = 11;

  localparam int unsigned YMIN_D   = 10;
  localparam int unsigned YMAX_D   = 450;
  localparam int unsigned HEIGHT_D = 100;
  localparam int unsigned YRESET_D = 190;
  localparam int unsigned XMIN_D   = 10;
  localparam int unsigned XMAX_D   = 630;

  typedef enum logic [1:0] {
    MV_HOLD = 2'd0,
    MV_UP   = 2'd1,
    MV_DOWN = 2'd2
  } move_t;

  // Both buttons together cancel out, as does neither.
  function automatic move_t decode_move(input logic up, input logic down);
    move_t mv;
    mv = MV_HOLD;
    if (up && !down)      mv = MV_UP;
    else if (down && !up) mv = MV_DOWN;
    return mv;
  endfunction

endpackage

// File: rtl/paddles_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw button.
module debounce
  #(parameter int unsigned DEB_BITS = 16)
  (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
  );

  // The level toggles on the edge where the counter would reach all-ones,
  // so a new level must persist for 2^DEB_BITS-1 consecutive clocks.
  localparam logic [DEB_BITS-1:0] CNT_LAST = {{(DEB_BITS-1){1'b1}}, 1'b0};

  logic [1:0]          sync;
  logic [DEB_BITS-1:0] cnt;
  logic                stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= 2'b00;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign dout = stable;

endmodule

// File: rtl/paddles.sv
// Paddle position generator: debounced buttons move two paddle top edges
// by STEP pixels per frame tick, clamped to the playfield.
module paddles
  import paddles_pkg::*;
  #(
    parameter int unsigned TICK_BITS = 18,
    parameter int unsigned DEB_BITS  = 16,
    parameter int unsigned STEP      = 4,
    parameter int unsigned YMIN      = YMIN_D,
    parameter int unsigned YMAX      = YMAX_D,
    parameter int unsigned HEIGHT    = HEIGHT_D,
    parameter int unsigned YRESET    = YRESET_D
  )
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upi,
    input  logic             downi,
    input  logic             upd,
    input  logic             downd,
    output logic [POS_W-1:0] posbarraiy,
    output logic [POS_W-1:0] posbarrady
  );

  localparam logic [CALC_W-1:0] LO     = CALC_W'(YMIN);
  localparam logic [CALC_W-1:0] HI     = CALC_W'(YMAX - HEIGHT);
  localparam logic [CALC_W-1:0] STEP_C = CALC_W'(STEP);
  localparam logic [POS_W-1:0]  POS_RST = POS_W'(YRESET);

  logic up_l, down_l, up_r, down_r;

  debounce #(.DEB_BITS(DEB_BITS)) u_deb_upi   (.clk(clk), .rst_n(rst_n), .din(upi),   .dout(up_l));
  debounce #(.DEB_BITS(DEB_BITS)) u_deb_downi (.clk(clk), .rst_n(rst_n), .din(downi), .dout(down_l));
  debounce #(.DEB_BITS(DEB_BITS)) u_deb_upd   (.clk(clk), .rst_n(rst_n), .din(upd),   .dout(up_r));
  debounce #(.DEB_BITS(DEB_BITS)) u_deb_downd (.clk(clk), .rst_n(rst_n), .din(downd), .dout(down_r));

  logic [TICK_BITS-1:0] tick_cnt;
  logic                 tick;

  assign tick = &tick_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick_cnt + 1'b1;
  end

  // One extra bit keeps pos-STEP and pos+STEP from wrapping before the clamp.
  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] pos,
                                                input move_t mv);
    logic [CALC_W-1:0] p;
    logic [CALC_W-1:0] r;
    p = {1'b0, pos};
    r = p;
    case (mv)
      MV_UP:   r = (p < LO + STEP_C) ? LO : p - STEP_C;
      MV_DOWN: r = (p + STEP_C > HI) ? HI : p + STEP_C;
      default: r = p;
    endcase
    return r[POS_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      posbarraiy <= POS_RST;
      posbarrady <= POS_RST;
    end else if (tick) begin
      posbarraiy <= next_pos(posbarraiy, decode_move(up_l, down_l));
      posbarrady <= next_pos(posbarrady, decode_move(up_r, down_r));
    end
  end

endmodule

// File: tb/tb_paddles.sv
// Scoreboard bench for paddles with an 8-clock tick and 3-clock debounce.
module tb_paddles;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       upi = 1'b0, downi = 1'b0, upd = 1'b0, downd = 1'b0;
  logic [9:0] posbarraiy, posbarrady;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  logic [9:0] q_l[$];
  logic [9:0] q_r[$];
  logic [9:0] ml, mr;

  paddles #(.TICK_BITS(3), .DEB_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .upi(upi), .downi(downi), .upd(upd), .downd(downd),
    .posbarraiy(posbarraiy), .posbarrady(posbarrady)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; positions update on every 8th edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    if (rst_n && edge_n > 0 && edge_n % 8 == 0) begin
      if (q_l.size() > 0) begin
        logic [9:0] e;
        e = q_l.pop_front();
        vectors++;
        if (posbarraiy !== e) begin
          miscompares++;
          $display("FAIL left_pos edge %0d: got %0d expected %0d", edge_n, posbarraiy, e);
        end
      end
      if (q_r.size() > 0) begin
        logic [9:0] e;
        e = q_r.pop_front();
        vectors++;
        if (posbarrady !== e) begin
          miscompares++;
          $display("FAIL right_pos edge %0d: got %0d expected %0d", edge_n, posbarrady, e);
        end
      end
    end
  end

  function automatic logic [9:0] model(input logic [9:0] p, input bit u, input bit d);
    int v;
    v = int'(p);
    if (u && !d)      v = (v - 4 < 10)  ? 10  : v - 4;
    else if (d && !u) v = (v + 4 > 350) ? 350 : v + 4;
    return v[9:0];
  endfunction

  task automatic push_ticks(input int n, input bit ul, input bit dl, input bit ur, input bit dr);
    for (int i = 0; i < n; i++) begin
      ml = model(ml, ul, dl);
      mr = model(mr, ur, dr);
      q_l.push_back(ml);
      q_r.push_back(mr);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q_l.size() > 0 || q_r.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q_l.size() > 0 || q_r.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q_l.size() + q_r.size());
      q_l.delete();
      q_r.delete();
    end
  endtask

  // Asserts reset between edges, checks it acts at once, releases on a negedge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (posbarraiy !== 10'd190) begin
      miscompares++;
      $display("FAIL %s_left_async: got %0d expected 190", tag, posbarraiy);
    end
    vectors++;
    if (posbarrady !== 10'd190) begin
      miscompares++;
      $display("FAIL %s_right_async: got %0d expected 190", tag, posbarrady);
    end
    ml = 10'd190;
    mr = 10'd190;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic release_buttons();
    upi = 1'b0; downi = 1'b0; upd = 1'b0; downd = 1'b0;
  endtask

  task automatic test_reset();
    do_reset("reset");
    push_ticks(12, 0, 0, 0, 0);
    wait_drain(12 * 8 + 16);
  endtask

  task automatic test_left_up();
    do_reset("left_up");
    upi = 1'b1;
    push_ticks(55, 1, 0, 0, 0);
    wait_drain(55 * 8 + 16);
    vectors++;
    if (posbarraiy !== 10'd10) begin
      miscompares++;
      $display("FAIL left_up_floor: got %0d expected 10", posbarraiy);
    end
    release_buttons();
  endtask

  task automatic test_right_down();
    do_reset("right_down");
    downd = 1'b1;
    push_ticks(45, 0, 0, 0, 1);
    wait_drain(45 * 8 + 16);
    vectors++;
    if (posbarrady !== 10'd350) begin
      miscompares++;
      $display("FAIL right_down_ceiling: got %0d expected 350", posbarrady);
    end
    release_buttons();
  endtask

  task automatic test_glitch();
    do_reset("glitch");
    push_ticks(5, 0, 0, 0, 0);
    for (int j = 0; j < 40; j++) begin
      upi = ((j % 10) < 2);
      @(negedge clk);
      #1;
    end
    upi = 1'b0;
    wait_drain(16);
    // Pulse placed so the accepted level overlaps exactly one tick.
    while (edge_n % 8 != 1) @(negedge clk);
    #1 upi = 1'b1;
    push_ticks(1, 1, 0, 0, 0);
    push_ticks(2, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    #1 upi = 1'b0;
    wait_drain(3 * 8 + 16);
  endtask

  task automatic test_conflict();
    do_reset("conflict");
    upi = 1'b1; downi = 1'b1; downd = 1'b1;
    push_ticks(10, 1, 1, 0, 1);
    wait_drain(10 * 8 + 16);
    release_buttons();
  endtask

  task automatic test_reset_mid_motion();
    do_reset("mid_pre");
    downi = 1'b1;
    push_ticks(15, 0, 1, 0, 0);
    wait_drain(15 * 8 + 16);
    vectors++;
    if (posbarraiy !== 10'd250) begin
      miscompares++;
      $display("FAIL mid_reach_250: got %0d expected 250", posbarraiy);
    end
    do_reset("mid_motion");
    push_ticks(3, 0, 1, 0, 0);
    repeat (6) @(negedge clk);
    vectors++;
    if (posbarraiy !== 10'd190) begin
      miscompares++;
      $display("FAIL mid_before_tick: got %0d expected 190", posbarraiy);
    end
    wait_drain(3 * 8 + 16);
    release_buttons();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    test_left_up();
    test_right_down();
    test_glitch();
    test_conflict();
    test_reset_mid_motion();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
